// File: rtl/apb_cmdq_pkg.sv
// Shared types and default sizes for the APB command queue.
package apb_cmdq_pkg;
    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 9;
    localparam int DW_DEF    = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic              write;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } cmd_t;
endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous FIFO of command entries; a push while full is dropped, pointers wrap modulo DEPTH.
module apb_cmd_fifo
    import apb_cmdq_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = cmd_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push_en;
    logic          pop_en;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_en) wptr <= wptr + PW'(1);
            if (pop_en)  rptr <= rptr + PW'(1);
            if (push_en && !pop_en)      level <= level + LW'(1);
            else if (pop_en && !push_en) level <= level - LW'(1);
        end
    end
endmodule

// File: rtl/apb_cmd_queue.sv
// Buffers valid/ready requests and issues them to the APB bridge one at a time, one response each.
// Optional abort timer for stalled accesses: define APB_CMDQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | bridge outputs 0; pops the FIFO head into the bridge outputs when one is queued
// ACTIVE | bridge outputs held; ends on xfer_done (or on timer expiry when enabled)
module apb_cmd_queue
    import apb_cmdq_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [AW-1:0]          req_addr,
    input  logic [DW-1:0]          req_wdata,
    output logic                   transfer,
    output logic                   wr_rd,
    output logic [AW-1:0]          wr_addr,
    output logic [AW-1:0]          rd_addr,
    output logic [DW-1:0]          wr_data,
    input  logic                   xfer_done,
    input  logic                   pslverr,
    input  logic [DW-1:0]          read_data,
    output logic                   rsp_valid,
    output logic                   rsp_err,
    output logic [DW-1:0]          rsp_data,
    output logic [$clog2(DEPTH):0] level
);
    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_w_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("apb_cmd_queue: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_cmd_queue: TIMEOUT must be >= 1");
    end

    cmd_w_t push_cmd;
    cmd_w_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   end_cmd;
    state_t state;

    assign push_cmd  = {req_write, req_addr, req_wdata};
    assign req_ready = !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;

    apb_cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (cmd_w_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid && req_ready),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

`ifdef APB_CMDQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr;

    // Down-counter reloaded at issue; reaching zero in ACTIVE means TIMEOUT cycles have elapsed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 tmr <= '0;
        else if (pop)               tmr <= TW'(TIMEOUT - 1);
        else if (state == ACTIVE && tmr != '0) tmr <= tmr - TW'(1);
    end

    assign end_cmd = xfer_done || (tmr == '0);
`else
    assign end_cmd = xfer_done;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            transfer  <= 1'b0;
            wr_rd     <= 1'b0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            wr_data   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= ACTIVE;
                        transfer <= 1'b1;
                        wr_rd    <= head.write;
                        wr_addr  <= head.write ? head.addr  : '0;
                        rd_addr  <= head.write ? '0 : head.addr;
                        wr_data  <= head.write ? head.wdata : '0;
                    end
                end
                ACTIVE: begin
                    if (end_cmd) begin
                        state     <= IDLE;
                        transfer  <= 1'b0;
                        wr_rd     <= 1'b0;
                        wr_addr   <= '0;
                        rd_addr   <= '0;
                        wr_data   <= '0;
                        rsp_valid <= 1'b1;
                        // Without xfer_done this is a timer abort: forced error, no data.
                        rsp_err   <= xfer_done ? pslverr : 1'b1;
                        rsp_data  <= (xfer_done && !wr_rd) ? read_data : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
